rob_commit_unit: RTL and testbench

- In-order retirement and allocation controller for the reorder buffer. It owns the head/tail pointers and the occupancy count.
- It allocates tags at issue and reads the head entry through the ROB read port. Completed instructions retire to the register file or the memory write path.
- It frees retired entries and raises a flush on an excepting head entry.
- It sits between issue/rename and the ROB storage, and is the reader and pointer owner for the ROB's writers.

---
 rtl/rob_commit_unit.sv | 142 ++++++++++++++
 tb/tb_rob_commit_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit_unit.sv
// In-order ROB retirement/allocation controller: owns head/tail/occupancy, retires the
// head entry to the register file or store path, and flushes on an excepting head.
module rob_commit_unit #(
  parameter int unsigned ROB_WIDTH           = 3,
  parameter int unsigned DATA_SIZE           = 32,
  parameter int unsigned PHYSICAL_ADDR_WIDTH = 20,
  parameter int unsigned VIRTUAL_ADDR_WIDTH  = 32,
  parameter int unsigned INSTRUCTION_WIDTH   = 32,
  parameter int unsigned ROB_STATE_WIDTH     = 2,
  parameter logic [6:0]  OPCODE_STORE        = 7'b0010001,
  parameter logic [6:0]  OPCODE_NOP          = 7'b0000000
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           alloc_req,
  output logic                           alloc_ack,
  output logic [ROB_WIDTH-1:0]           alloc_tag,
  output logic [ROB_WIDTH-1:0]           head,
  output logic [ROB_WIDTH-1:0]           tail,
  output logic [ROB_WIDTH:0]             empty_entries,
  output logic [ROB_WIDTH-1:0]           tag_read,
  input  logic [ROB_STATE_WIDTH-1:0]     state_read,
  input  logic [PHYSICAL_ADDR_WIDTH-1:0] addr_read,
  input  logic [DATA_SIZE-1:0]           value_read,
  input  logic [VIRTUAL_ADDR_WIDTH-1:0]  pc_read,
  input  logic [INSTRUCTION_WIDTH-1:0]   instr_read,
  input  logic                           commit_stall,
  output logic                           rf_we,
  output logic [4:0]                     rf_waddr,
  output logic [DATA_SIZE-1:0]           rf_wdata,
  output logic                           mem_we,
  output logic [PHYSICAL_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]           mem_wdata,
  output logic                           clr_we,
  output logic [ROB_WIDTH-1:0]           clr_tag,
  output logic                           flush,
  output logic                           exc_valid,
  output logic [VIRTUAL_ADDR_WIDTH-1:0]  exc_pc
);

  localparam logic [ROB_WIDTH:0]           Depth        = {1'b1, {ROB_WIDTH{1'b0}}};
  localparam logic [ROB_STATE_WIDTH-1:0]   RobComplete  = ROB_STATE_WIDTH'(2);
  localparam logic [ROB_STATE_WIDTH-1:0]   RobException = ROB_STATE_WIDTH'(3);

  typedef enum logic [0:0] {StRun, StFlush} fsm_e;

  fsm_e                 state_q;
  logic [ROB_WIDTH-1:0] head_q, tail_q;
  logic [ROB_WIDTH:0]   count_q, count_d;
  logic                 in_run, exc_hit, commit_go;
  logic [6:0]           opcode;

  assign in_run    = (state_q == StRun);
  assign opcode    = instr_read[31:25];
  assign exc_hit   = in_run && (count_q != '0) && (state_read == RobException);
  assign commit_go = in_run && (count_q != '0) && !commit_stall && (state_read == RobComplete);
  // Grant is held off during reset and in the exception cycle; full uses pre-edge count.
  assign alloc_ack = reset && alloc_req && in_run && (count_q < Depth) && !exc_hit;

  assign alloc_tag = tail_q;
  assign head      = head_q;
  assign tail      = tail_q;
  assign tag_read  = head_q;

  always_comb begin
    count_d = count_q;
    if (alloc_ack && !commit_go) begin
      count_d = count_q + 1'b1;
    end else if (commit_go && !alloc_ack) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StRun;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      empty_entries <= Depth;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      clr_we        <= 1'b0;
      clr_tag       <= '0;
      flush         <= 1'b0;
      exc_valid     <= 1'b0;
      exc_pc        <= '0;
    end else begin
      rf_we     <= 1'b0;
      mem_we    <= 1'b0;
      clr_we    <= 1'b0;
      flush     <= 1'b0;
      exc_valid <= 1'b0;
      unique case (state_q)
        StRun: begin
          if (exc_hit) begin
            // Pointers clear on entry so the FLUSH cycle already presents an empty ROB.
            state_q       <= StFlush;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            empty_entries <= Depth;
            flush         <= 1'b1;
            exc_valid     <= 1'b1;
            exc_pc        <= pc_read;
          end else begin
            if (alloc_ack) begin
              tail_q <= tail_q + 1'b1;
            end
            if (commit_go) begin
              head_q  <= head_q + 1'b1;
              clr_we  <= 1'b1;
              clr_tag <= head_q;
              if (opcode == OPCODE_STORE) begin
                mem_we    <= 1'b1;
                mem_addr  <= addr_read;
                mem_wdata <= value_read;
              end else if (opcode != OPCODE_NOP) begin
                rf_we    <= 1'b1;
                rf_waddr <= instr_read[24:20];
                rf_wdata <= value_read;
              end
            end
            count_q       <= count_d;
            empty_entries <= Depth - count_d;
          end
        end
        StFlush: begin
          state_q <= StRun;
        end
        default: begin
          state_q <= StRun;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Directed bench for rob_commit_unit: allocation, retirement, stall, exception and wrap.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alloc_req;
  logic        alloc_ack;
  logic [2:0]  alloc_tag, head, tail, tag_read;
  logic [3:0]  empty_entries;
  logic [1:0]  state_read;
  logic [19:0] addr_read;
  logic [31:0] value_read, pc_read, instr_read;
  logic        commit_stall;
  logic        rf_we, mem_we, clr_we, flush, exc_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, mem_wdata, exc_pc;
  logic [19:0] mem_addr;
  logic [2:0]  clr_tag;

  int pass_cnt = 0;
  int total_cnt = 0;

  localparam logic [1:0] SFree = 2'd0, SBusy = 2'd1, SComp = 2'd2, SExc = 2'd3;

  always #5 clk = ~clk;

  rob_commit_unit dut (
    .clk(clk), .reset(reset), .alloc_req(alloc_req), .alloc_ack(alloc_ack),
    .alloc_tag(alloc_tag), .head(head), .tail(tail), .empty_entries(empty_entries),
    .tag_read(tag_read), .state_read(state_read), .addr_read(addr_read),
    .value_read(value_read), .pc_read(pc_read), .instr_read(instr_read),
    .commit_stall(commit_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .clr_we(clr_we),
    .clr_tag(clr_tag), .flush(flush), .exc_valid(exc_valid), .exc_pc(exc_pc)
  );

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [4:0] rd);
    return {op, rd, 20'h0};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req = 0; state_read = SFree; addr_read = '0; value_read = '0;
    pc_read = '0; instr_read = '0; commit_stall = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    cyc();
    cyc();
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    alloc_req = 1;
    reset = 0;
    cyc();
    cyc();
    total_cnt++;
    if (alloc_ack !== 1'b0 || head !== 3'd0 || tail !== 3'd0 || empty_entries !== 4'd8) begin
      $display("FAIL reset_state: ack=%b head=%0d tail=%0d empty=%0d, want 0 0 0 8",
               alloc_ack, head, tail, empty_entries);
    end else pass_cnt++;
    total_cnt++;
    if (rf_we !== 0 || mem_we !== 0 || clr_we !== 0 || flush !== 0 || exc_valid !== 0 ||
        exc_pc !== 0 || rf_wdata !== 0) begin
      $display("FAIL reset_strobes: rf=%b mem=%b clr=%b fl=%b exc=%b pc=%h, want all 0",
               rf_we, mem_we, clr_we, flush, exc_valid, exc_pc);
    end else pass_cnt++;
    reset = 1;
    #1;
    total_cnt++;
    if (alloc_ack !== 1'b1 || alloc_tag !== 3'd0) begin
      $display("FAIL reset_release: ack=%b tag=%0d, want 1 0", alloc_ack, alloc_tag);
    end else pass_cnt++;
    alloc_req = 0;
  endtask

  task automatic test_full();
    do_reset();
    alloc_req = 1; state_read = SBusy;
    for (int i = 0; i < 8; i++) begin
      #1;
      total_cnt++;
      if (alloc_ack !== 1'b1 || alloc_tag !== 3'(i)) begin
        $display("FAIL fill_tag%0d: ack=%b tag=%0d, want 1 %0d", i, alloc_ack, alloc_tag, i);
      end else pass_cnt++;
      cyc();
    end
    total_cnt++;
    if (alloc_ack !== 1'b0 || empty_entries !== 4'd0) begin
      $display("FAIL full: ack=%b empty=%0d, want 0 0", alloc_ack, empty_entries);
    end else pass_cnt++;
    state_read = SComp; instr_read = mk_instr(7'b0000001, 5'd3); value_read = 32'h55;
    #1;
    total_cnt++;
    if (alloc_ack !== 1'b0) begin
      $display("FAIL full_commit_ack: ack=%b, want 0", alloc_ack);
    end else pass_cnt++;
    cyc();
    alloc_req = 0; state_read = SBusy;
    total_cnt++;
    if (rf_we !== 1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h55 || clr_we !== 1 ||
        clr_tag !== 3'd0 || head !== 3'd1 || tail !== 3'd0 || empty_entries !== 4'd1) begin
      $display("FAIL full_commit: we=%b wa=%0d wd=%h clr=%b ct=%0d h=%0d t=%0d e=%0d, want 1 3 55 1 0 1 0 1",
               rf_we, rf_waddr, rf_wdata, clr_we, clr_tag, head, tail, empty_entries);
    end else pass_cnt++;
    cyc();
    total_cnt++;
    if (rf_we !== 0 || clr_we !== 0 || head !== 3'd1) begin
      $display("FAIL pulse_width: rf_we=%b clr_we=%b head=%0d, want 0 0 1", rf_we, clr_we, head);
    end else pass_cnt++;
  endtask

  task automatic test_store_stall();
    do_reset();
    alloc_req = 1;
    cyc();
    alloc_req = 0; state_read = SComp; instr_read = mk_instr(7'b0010001, 5'd7);
    addr_read = 20'h40; value_read = 32'h9; commit_stall = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total_cnt++;
      if (mem_we !== 0 || rf_we !== 0 || clr_we !== 0 || head !== 3'd0 || empty_entries !== 4'd7) begin
        $display("FAIL stall%0d: mem=%b rf=%b clr=%b head=%0d empty=%0d, want 0 0 0 0 7",
                 i, mem_we, rf_we, clr_we, head, empty_entries);
      end else pass_cnt++;
    end
    commit_stall = 0;
    cyc();
    state_read = SFree;
    total_cnt++;
    if (mem_we !== 1 || mem_addr !== 20'h40 || mem_wdata !== 32'h9 || rf_we !== 0 ||
        head !== 3'd1 || empty_entries !== 4'd8) begin
      $display("FAIL store: mem=%b addr=%h wd=%h rf=%b head=%0d empty=%0d, want 1 40 9 0 1 8",
               mem_we, mem_addr, mem_wdata, rf_we, head, empty_entries);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    alloc_req = 1;
    cyc();
    state_read = SComp; instr_read = mk_instr(7'b0000011, 5'd5); value_read = 32'h77;
    #1;
    total_cnt++;
    if (alloc_ack !== 1'b1 || alloc_tag !== 3'd1) begin
      $display("FAIL b2b_ack: ack=%b tag=%0d, want 1 1", alloc_ack, alloc_tag);
    end else pass_cnt++;
    cyc();
    alloc_req = 0; instr_read = mk_instr(7'b0000000, 5'd9);
    total_cnt++;
    if (head !== 3'd1 || tail !== 3'd2 || empty_entries !== 4'd7 || rf_we !== 1 ||
        rf_waddr !== 5'd5 || rf_wdata !== 32'h77) begin
      $display("FAIL b2b: h=%0d t=%0d e=%0d we=%b wa=%0d wd=%h, want 1 2 7 1 5 77",
               head, tail, empty_entries, rf_we, rf_waddr, rf_wdata);
    end else pass_cnt++;
    cyc();
    state_read = SFree;
    total_cnt++;
    if (rf_we !== 0 || mem_we !== 0 || clr_we !== 1 || clr_tag !== 3'd1 || head !== 3'd2 ||
        empty_entries !== 4'd8) begin
      $display("FAIL nop: rf=%b mem=%b clr=%b ct=%0d h=%0d e=%0d, want 0 0 1 1 2 8",
               rf_we, mem_we, clr_we, clr_tag, head, empty_entries);
    end else pass_cnt++;
  endtask

  task automatic test_exception();
    do_reset();
    alloc_req = 1;
    for (int i = 0; i < 4; i++) cyc();
    state_read = SExc; pc_read = 32'h1000; commit_stall = 1;
    #1;
    total_cnt++;
    if (alloc_ack !== 1'b0 || empty_entries !== 4'd4) begin
      $display("FAIL exc_ack: ack=%b empty=%0d, want 0 4", alloc_ack, empty_entries);
    end else pass_cnt++;
    cyc();
    state_read = SFree; commit_stall = 0;
    #1;
    total_cnt++;
    if (flush !== 1 || exc_valid !== 1 || exc_pc !== 32'h1000 || rf_we !== 0 ||
        alloc_ack !== 0 || head !== 0 || tail !== 0) begin
      $display("FAIL exc_flush: fl=%b ev=%b pc=%h rf=%b ack=%b h=%0d t=%0d, want 1 1 1000 0 0 0 0",
               flush, exc_valid, exc_pc, rf_we, alloc_ack, head, tail);
    end else pass_cnt++;
    cyc();
    total_cnt++;
    if (flush !== 0 || exc_valid !== 0 || head !== 0 || tail !== 0 || empty_entries !== 4'd8 ||
        alloc_ack !== 1) begin
      $display("FAIL exc_after: fl=%b ev=%b h=%0d t=%0d e=%0d ack=%b, want 0 0 0 0 8 1",
               flush, exc_valid, head, tail, empty_entries, alloc_ack);
    end else pass_cnt++;
    alloc_req = 0;
  endtask

  task automatic test_wrap();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      alloc_req = 1; state_read = SBusy;
      #1;
      if (alloc_ack !== 1 || alloc_tag !== 3'(i % 8) || tail !== 3'(i % 8)) bad++;
      cyc();
      alloc_req = 0; state_read = SComp;
      instr_read = mk_instr(7'b0000100, 5'(i)); value_read = 32'(i + 100);
      #1;
      if (head !== 3'(i % 8)) bad++;
      cyc();
      state_read = SFree;
      if (rf_we !== 1 || rf_wdata !== 32'(i + 100) || clr_tag !== 3'(i % 8) ||
          empty_entries !== 4'd8) bad++;
    end
    total_cnt++;
    if (bad != 0 || head !== 3'd4 || tail !== 3'd4) begin
      $display("FAIL wrap: errors=%0d head=%0d tail=%0d, want 0 4 4", bad, head, tail);
    end else pass_cnt++;
    // Reset asserted during the FLUSH cycle must win.
    alloc_req = 1;
    cyc();
    alloc_req = 0; state_read = SExc; pc_read = 32'hABC;
    cyc();
    state_read = SFree; reset = 0;
    cyc();
    total_cnt++;
    if (flush !== 0 || exc_valid !== 0 || exc_pc !== 0 || head !== 0 || tail !== 0 ||
        empty_entries !== 4'd8) begin
      $display("FAIL reset_in_flush: fl=%b ev=%b pc=%h h=%0d t=%0d e=%0d, want 0 0 0 0 0 8",
               flush, exc_valid, exc_pc, head, tail, empty_entries);
    end else pass_cnt++;
    reset = 1;
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    test_reset();
    test_full();
    test_store_stall();
    test_back_to_back();
    test_exception();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
